// File: rtl/adc_clk_supervisor_if.sv
// Signal bundle between the ADC clock supervisor and its PLL / ADC-front-end environment.
interface adc_clk_supervisor_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);
    logic                    pll_lock;
    logic                    stdby_req;
    logic                    sync;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic [NUM_CH*DIV_W-1:0] ch_phase;
    logic                    pll_reset;
    logic                    pll_stdby;
    logic                    ready;
    logic [NUM_CH-1:0]       ch_ce;
    logic                    lost_lock;
    logic [7:0]              retry_cnt;

    modport master (
        output pll_lock, stdby_req, sync, ch_en, ch_div, ch_phase,
        input  pll_reset, pll_stdby, ready, ch_ce, lost_lock, retry_cnt
    );

    modport slave (
        input  pll_lock, stdby_req, sync, ch_en, ch_div, ch_phase,
        output pll_reset, pll_stdby, ready, ch_ce, lost_lock, retry_cnt
    );
endinterface

// File: rtl/adc_clk_supervisor.sv
// PLL supervisor (reset/standby/lock qualification with timeout retry) driving NUM_CH
// independently divided, phase-offset sample-enable strobes once lock is qualified.
module adc_clk_supervisor #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned RST_HOLD  = 8,
    parameter int unsigned LOCK_FILT = 16,
    parameter int unsigned LOCK_TMO  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_clk_supervisor_if.slave bus
);

    localparam int unsigned HW = (RST_HOLD  > 1) ? $clog2(RST_HOLD + 1) : 1;
    localparam int unsigned FW = $clog2(LOCK_FILT + 1);
    localparam int unsigned TW = $clog2(LOCK_TMO + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [FW-1:0] FILT_DONE = FW'(LOCK_FILT);
    localparam logic [TW-1:0] TMO_DONE  = TW'(LOCK_TMO);

    typedef enum logic [1:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_STDBY
    } state_e;

    state_e          state_q, state_d;
    logic            lock_m_q, lock_s_q;
    logic [HW-1:0]   hold_q, hold_d;
    logic [FW-1:0]   filt_q, filt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      retry_q, retry_d;
    logic            lost_q, lost_d;
    logic            pll_reset_q, pll_stdby_q, ready_q;

    logic [DIV_W-1:0] cnt_q   [NUM_CH];
    logic [DIV_W-1:0] cnt_d   [NUM_CH];
    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] div_d   [NUM_CH];
    logic [DIV_W-1:0] ph_q    [NUM_CH];
    logic [DIV_W-1:0] ph_d    [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] ce_q, ce_d;

    logic run_next;
    logic run_entry;

    // Supervisor FSM: next state and qualification counters.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        filt_d  = '0;
        tmo_d   = '0;
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            ST_RST: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                filt_d = lock_s_q ? filt_q + FW'(1) : '0;
                tmo_d  = tmo_q + TW'(1);
                // Qualification is tested first so it wins a tie with the timeout.
                if (filt_d == FILT_DONE) begin
                    state_d = ST_RUN;
                    filt_d  = '0;
                    tmo_d   = '0;
                end else if (tmo_d == TMO_DONE) begin
                    state_d = ST_RST;
                    filt_d  = '0;
                    tmo_d   = '0;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_RST;
                    lost_d  = 1'b1;
                end else if (bus.stdby_req) begin
                    state_d = ST_STDBY;
                end
            end
            ST_STDBY: begin
                if (!bus.stdby_req) begin
                    state_d = ST_RST;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    assign run_next  = (state_d == ST_RUN);
    assign run_entry = (state_q != ST_RUN);

    // Channel engine. Shadows reload on RUN entry, sync, re-enable and wrap; the strobe
    // is evaluated on the next-cycle counter so ch_ce is registered in step with cnt.
    always_comb begin
        en_d = '0;
        ce_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            div_d[i] = div_q[i];
            ph_d[i]  = ph_q[i];
            if (run_next && bus.ch_en[i]) begin
                en_d[i] = 1'b1;
                if (run_entry || bus.sync || !en_q[i] || (cnt_q[i] == div_q[i])) begin
                    cnt_d[i] = '0;
                    div_d[i] = bus.ch_div[i*DIV_W +: DIV_W];
                    ph_d[i]  = bus.ch_phase[i*DIV_W +: DIV_W];
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
                ce_d[i] = (cnt_d[i] == ((ph_d[i] < div_d[i]) ? ph_d[i] : div_d[i]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            lock_m_q    <= 1'b0;
            lock_s_q    <= 1'b0;
            hold_q      <= '0;
            filt_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            pll_stdby_q <= 1'b0;
            ready_q     <= 1'b0;
            en_q        <= '0;
            ce_q        <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= '0;
                ph_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            lock_m_q    <= bus.pll_lock;
            lock_s_q    <= lock_m_q;
            hold_q      <= hold_d;
            filt_q      <= filt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_reset_q <= (state_d == ST_RST);
            pll_stdby_q <= (state_d == ST_STDBY);
            ready_q     <= (state_d == ST_RUN);
            en_q        <= en_d;
            ce_q        <= ce_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                ph_q[i]  <= ph_d[i];
            end
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.pll_stdby = pll_stdby_q;
    assign bus.ready     = ready_q;
    assign bus.ch_ce     = ce_q;
    assign bus.lost_lock = lost_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_adc_clk_supervisor.sv
// Scoreboard bench: a behavioural model pushes expected outputs each clock; a negedge monitor
// pops and compares them against the supervisor's registered outputs.
module tb_adc_clk_supervisor;

    localparam int NCH       = 4;
    localparam int DW        = 8;
    localparam int RST_HOLD  = 8;
    localparam int LOCK_FILT = 16;
    localparam int LOCK_TMO  = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_clk_supervisor_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

    adc_clk_supervisor #(
        .NUM_CH   (NCH),
        .DIV_W    (DW),
        .RST_HOLD (RST_HOLD),
        .LOCK_FILT(LOCK_FILT),
        .LOCK_TMO (LOCK_TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic           rst;
        logic           stb;
        logic           rdy;
        logic [NCH-1:0] ce;
        logic           lost;
        logic [7:0]     retry;
    } out_t;

    typedef enum {M_RST, M_WAIT, M_RUN, M_STDBY} mode_t;

    out_t  exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Model state: mode, time spent in it, consecutive-lock run length, and per-channel
    // period start time plus the divide/phase captured at that start.
    mode_t mode;
    int    t_in, good, retry, n;
    bit    lost;
    bit    lk[$];
    int    t0[NCH], sdiv[NCH], sph[NCH];
    bit    act[NCH];

    function automatic out_t reset_vec();
        out_t v;
        v     = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic out_t dut_out();
        out_t v;
        v.rst   = bus.pll_reset;
        v.stb   = bus.pll_stdby;
        v.rdy   = bus.ready;
        v.ce    = bus.ch_ce;
        v.lost  = bus.lost_lock;
        v.retry = bus.retry_cnt;
        return v;
    endfunction

    task automatic model_reset();
        mode  = M_RST;
        t_in  = 0;
        good  = 0;
        retry = 0;
        lost  = 1'b0;
        n     = 0;
        lk    = '{1'b0, 1'b0};
        for (int i = 0; i < NCH; i++) act[i] = 1'b0;
    endtask

    task automatic model_step();
        bit             ls;
        bit             entering;
        mode_t          nm;
        logic [NCH-1:0] ce_m;
        int             pos, tgt;
        out_t           e;
        n++;
        ls = lk.pop_front();
        lk.push_back(bus.pll_lock);
        nm = mode;
        t_in++;
        case (mode)
            M_RST:   if (t_in == RST_HOLD) nm = M_WAIT;
            M_WAIT: begin
                good = ls ? good + 1 : 0;
                if (good == LOCK_FILT) nm = M_RUN;
                else if (t_in == LOCK_TMO) begin
                    nm = M_RST;
                    if (retry < 255) retry++;
                end
            end
            M_RUN: begin
                if (!ls) begin
                    nm   = M_RST;
                    lost = 1'b1;
                end else if (bus.stdby_req) nm = M_STDBY;
            end
            M_STDBY: if (!bus.stdby_req) nm = M_RST;
            default: nm = M_RST;
        endcase
        entering = (mode != M_RUN);
        if (nm != mode) begin
            t_in = 0;
            good = 0;
        end
        mode = nm;

        ce_m = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mode == M_RUN && bus.ch_en[i]) begin
                if (entering || bus.sync || !act[i] || (n - t0[i]) > sdiv[i]) begin
                    t0[i]   = n;
                    sdiv[i] = int'(bus.ch_div[i*DW +: DW]);
                    sph[i]  = int'(bus.ch_phase[i*DW +: DW]);
                end
                act[i]  = 1'b1;
                pos     = n - t0[i];
                tgt     = (sph[i] < sdiv[i]) ? sph[i] : sdiv[i];
                ce_m[i] = (pos == tgt);
            end else begin
                act[i] = 1'b0;
            end
        end

        e.rst   = (mode == M_RST);
        e.stb   = (mode == M_STDBY);
        e.rdy   = (mode == M_RUN);
        e.ce    = ce_m;
        e.lost  = lost;
        e.retry = 8'(retry);
        exp_q.push_back(e);
    endtask

    // Reference model, clocked.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                exp_q.push_back(reset_vec());
            end else begin
                model_step();
            end
        end
    end

    // Asynchronous reset overrides whatever the current cycle was expected to show.
    initial begin
        forever begin
            @(negedge rst_n);
            model_reset();
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = reset_vec();
        end
    end

    // Monitor.
    initial begin
        out_t e, g;
        forever begin
            @(negedge clk);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty @%0t: no expected vector queued", $time);
            end else begin
                e = exp_q.pop_front();
                g = dut_out();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t got rst=%b stb=%b rdy=%b ce=%b lost=%b retry=%0d exp rst=%b stb=%b rdy=%b ce=%b lost=%b retry=%0d",
                             $time, g.rst, g.stb, g.rdy, g.ce, g.lost, g.retry,
                             e.rst, e.stb, e.rdy, e.ce, e.lost, e.retry);
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int c;
        c = 0;
        while (!bus.ready && c < budget) begin
            tick(1);
            c++;
        end
        vectors++;
        if (!bus.ready) begin
            miscompares++;
            $display("FAIL %s timeout: ready=%b after %0d cycles, required 1", tag, bus.ready, c);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        out_t g;
        rst_n         = 1'b0;
        bus.pll_lock  = 1'b1;
        bus.stdby_req = 1'b0;
        bus.sync      = 1'b0;
        bus.ch_en     = '1;
        bus.ch_div    = {8'd4, 8'd9, 8'd0, 8'd3};
        bus.ch_phase  = {8'd7, 8'd2, 8'd0, 8'd1};
        tick(3);
        rst_n = 1'b1;
        wait_ready(100, "initial_lock");
        tick(40);

        // Mid-period divide change, then a realigning sync pulse.
        bus.ch_div[7:0] = 8'd7;
        tick(30);
        bus.sync = 1'b1;
        tick(1);
        bus.sync = 1'b0;
        tick(30);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, NCH-1));
                bus.ch_en[idx] = ~bus.ch_en[idx];
            end
            if ($urandom_range(0, 9) == 0) begin
                idx = int'($urandom_range(0, NCH-1));
                bus.ch_div[idx*DW +: DW]   = 8'($urandom_range(0, 12));
                bus.ch_phase[idx*DW +: DW] = 8'($urandom_range(0, 15));
            end
            bus.sync = ($urandom_range(0, 24) == 0);
            tick(1);
        end
        bus.sync  = 1'b0;
        bus.ch_en = '1;
        tick(10);

        // Lock loss in RUN, then re-lock.
        bus.pll_lock = 1'b0;
        tick(4);
        bus.pll_lock = 1'b1;
        wait_ready(200, "relock");
        tick(20);

        // Standby entry and exit.
        bus.stdby_req = 1'b1;
        tick(20);
        bus.stdby_req = 1'b0;
        wait_ready(200, "stdby_exit");
        tick(10);

        // Lock chatter that never qualifies: expect timeouts and retries.
        bus.pll_lock = 1'b0;
        for (int k = 0; k < 230; k++) begin
            tick(10);
            bus.pll_lock = ~bus.pll_lock;
        end
        bus.pll_lock = 1'b1;
        wait_ready(1200, "after_retries");
        tick(20);

        // Asynchronous reset mid-RUN must take effect before the next clock edge.
        rst_n = 1'b0;
        #1;
        g = dut_out();
        vectors++;
        if (g !== reset_vec()) begin
            miscompares++;
            $display("FAIL async_reset got rst=%b stb=%b rdy=%b ce=%b lost=%b retry=%0d required rst=1 stb=0 rdy=0 ce=0 lost=0 retry=0",
                     g.rst, g.stb, g.rdy, g.ce, g.lost, g.retry);
        end
        tick(2);
        rst_n = 1'b1;
        wait_ready(100, "post_reset_lock");
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
